// File: rtl/abh_pkg.sv
// abh_pkg: shared definitions for the 65C02 address-bus-high stage.
// ADH op encodings, fix-up FSM state, fixed page numbers and an op
// classifier used by the page-cross fix-up logic.
// Optional feature macro: ABH_PAGE_FIX_EN (enables the fix-up FSM).
package abh_pkg;

  // ADH operation encodings; 4'h9..4'hF behave as ABH_HOLD.
  localparam logic [3:0] ABH_HOLD = 4'h0;
  localparam logic [3:0] ABH_PC   = 4'h1;
  localparam logic [3:0] ABH_INC  = 4'h2;
  localparam logic [3:0] ABH_ZP   = 4'h3;
  localparam logic [3:0] ABH_STK  = 4'h4;
  localparam logic [3:0] ABH_VEC  = 4'h5;
  localparam logic [3:0] ABH_ABS  = 4'h6;
  localparam logic [3:0] ABH_IND  = 4'h7;
  localparam logic [3:0] ABH_BRA  = 4'h8;

  // Fixed high-address pages.
  localparam logic [7:0] ZP_PAGE  = 8'h00;
  localparam logic [7:0] STK_PAGE = 8'h01;
  localparam logic [7:0] VEC_PAGE = 8'hFF;

  // Fix-up correction amounts (mod 256).
  localparam logic [7:0] DELTA_INC = 8'h01;
  localparam logic [7:0] DELTA_DEC = 8'hFF;

  // Fix-up FSM: RUN is normal operation, FIX is the inserted
  // correction cycle after a page cross.
  typedef enum logic {
    RUN = 1'b0,
    FIX = 1'b1
  } abh_state_e;

  // How an op participates in page-cross detection.
  //   CLS_NONE : never needs a correction
  //   CLS_ADDR : ABS/IND, cross when the ADL carry is set
  //   CLS_BRA  : relative branch, cross when carry differs from sign
  typedef enum logic [1:0] {
    CLS_NONE = 2'd0,
    CLS_ADDR = 2'd1,
    CLS_BRA  = 2'd2
  } op_class_e;

  function automatic op_class_e op_class(input logic [3:0] op_in);
    op_class_e cls;
    cls = CLS_NONE;
    case (op_in)
      ABH_ABS,
      ABH_IND: cls = CLS_ADDR;
      ABH_BRA: cls = CLS_BRA;
      default: cls = CLS_NONE;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/abh_fixup.sv
// abh_fixup: page-cross fix-up FSM and correction (delta) register.
// Only instantiated when ABH_PAGE_FIX_EN is defined.
//
// A page cross is detected combinationally in RUN; fix_o is raised in that
// same cycle and, when rdy is high, the FSM moves to FIX for exactly one
// enabled cycle while delta_q remembers whether the correction is +1 or -1.
// The current state is exported on state_o so it can be observed directly.
module abh_fixup
  import abh_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  input  op_class_e  op_cls_i,
  input  logic       ci_i,
  input  logic       neg_i,
  output abh_state_e state_o,
  output logic [7:0] delta_o,
  output logic       fix_o
);

  abh_state_e state_q;
  logic [7:0] delta_q;
  logic       need_fix;
  logic       dec_fix;

  // Page-cross detection: ABS/IND cross on carry, branches cross when the
  // low-byte carry disagrees with the offset sign.
  always_comb begin
    need_fix = 1'b0;
    dec_fix  = 1'b0;
    case (op_cls_i)
      CLS_ADDR: need_fix = ci_i;
      CLS_BRA: begin
        need_fix = ci_i ^ neg_i;
        dec_fix  = neg_i & ~ci_i;
      end
      default: need_fix = 1'b0;
    endcase
  end

  // fix is only requested from RUN; in FIX the op is ignored.
  assign fix_o   = (state_q == RUN) && need_fix;
  assign state_o = state_q;
  assign delta_o = delta_q;

  // FSM and delta register; everything freezes while rdy is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      delta_q <= DELTA_INC;
    end else if (rdy) begin
      case (state_q)
        RUN: begin
          if (need_fix) begin
            state_q <= FIX;
            delta_q <= dec_fix ? DELTA_DEC : DELTA_INC;
          end
        end
        FIX: begin
          state_q <= RUN;
        end
      endcase
    end
  end

endmodule

// File: rtl/abh.sv
// abh: Address Bus High stage of the 65C02 datapath.
// Produces the combinational next high address ADH, the registered ABH,
// the program counter high byte PCH and the page-cross request fix.
// Optional feature macro: ABH_PAGE_FIX_EN
//   defined   : page-crossing ABS/IND/BRA addresses take one extra cycle;
//               the uncorrected page is issued first and fixed next cycle.
//   undefined : the ADL carry is always applied in the same cycle and
//               fix is tied low.
module abh
  import abh_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  input  logic       CI,
  input  logic       neg,
  input  logic [7:0] DB,
  input  logic [3:0] op,
  input  logic       ld_ahh,
  input  logic       ld_pc,
  input  logic       pcl_co,
  output logic [7:0] ADH,
  output logic [7:0] ABH,
  output logic [7:0] PCH,
  output logic       fix
);

  logic [7:0] abh_q;
  logic [7:0] pch_q;
  logic [7:0] ahh_q;
  logic [7:0] adh_d;
  logic [7:0] pch_d;
  logic [7:0] carry8;
  logic [7:0] adh_full;

  assign carry8 = {7'd0, CI};

  // ADH as listed by op with the carry applied in the same cycle.
  always_comb begin
    adh_full = abh_q;
    case (op)
      ABH_HOLD: adh_full = abh_q;
      ABH_PC:   adh_full = pch_q;
      ABH_INC:  adh_full = abh_q + carry8;
      ABH_ZP:   adh_full = ZP_PAGE;
      ABH_STK:  adh_full = STK_PAGE;
      ABH_VEC:  adh_full = VEC_PAGE;
      ABH_ABS:  adh_full = DB + carry8;
      ABH_IND:  adh_full = ahh_q + carry8;
      ABH_BRA:  adh_full = abh_q + {8{neg}} + carry8;
      default:  adh_full = abh_q;
    endcase
  end

`ifdef ABH_PAGE_FIX_EN
  abh_state_e fix_state;
  logic [7:0] fix_delta;
  logic       fix_req;
  op_class_e  op_cls;

  assign op_cls = op_class(op);

  abh_fixup u_fixup (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .op_cls_i (op_cls),
    .ci_i     (CI),
    .neg_i    (neg),
    .state_o  (fix_state),
    .delta_o  (fix_delta),
    .fix_o    (fix_req)
  );

  // Page-cross handling: on detection issue the page the address started
  // in (DB for ABS, AHH for IND, current ABH for a branch) and correct it
  // by delta in the following FIX cycle, whatever op is then presented.
  always_comb begin
    adh_d = adh_full;
    if (fix_state == FIX) begin
      adh_d = abh_q + fix_delta;
    end else if (fix_req) begin
      case (op)
        ABH_ABS: adh_d = DB;
        ABH_IND: adh_d = ahh_q;
        default: adh_d = abh_q;
      endcase
    end
  end

  assign fix = fix_req;
`else
  assign adh_d = adh_full;
  assign fix   = 1'b0;
`endif

  assign ADH = adh_d;

  // PCH increments off the registered ABH, wrapping FF -> 00.
  assign pch_d = abh_q + {7'd0, pcl_co};

  // Address, program counter and AHH hold registers; rdy low freezes all.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      abh_q <= 8'h00;
      pch_q <= 8'h00;
      ahh_q <= 8'h00;
    end else if (rdy) begin
      abh_q <= adh_d;
      if (ld_pc) begin
        pch_q <= pch_d;
      end
      if (ld_ahh) begin
        ahh_q <= DB;
      end
    end
  end

  assign ABH = abh_q;
  assign PCH = pch_q;

endmodule

// File: tb/tb_abh.sv
// tb_abh: self-checking bench for abh.
// Expected outputs for each cycle are pushed into exp_q by the driver from
// a page-level reference model; a monitor pops and compares on the falling
// edge. Works for both builds of ABH_PAGE_FIX_EN.
module tb_abh;
  import abh_pkg::*;

`ifdef ABH_PAGE_FIX_EN
  localparam bit FIX_EN = 1'b1;
`else
  localparam bit FIX_EN = 1'b0;
`endif

  localparam int EW = 25;  // {fix, ADH, ABH, PCH}

  logic       clk;
  logic       rst;
  logic       rdy;
  logic       CI;
  logic       neg;
  logic [7:0] DB;
  logic [3:0] op;
  logic       ld_ahh;
  logic       ld_pc;
  logic       pcl_co;
  logic [7:0] ADH;
  logic [7:0] ABH;
  logic [7:0] PCH;
  logic       fix;

  abh dut (
    .clk    (clk),
    .rst    (rst),
    .rdy    (rdy),
    .CI     (CI),
    .neg    (neg),
    .DB     (DB),
    .op     (op),
    .ld_ahh (ld_ahh),
    .ld_pc  (ld_pc),
    .pcl_co (pcl_co),
    .ADH    (ADH),
    .ABH    (ABH),
    .PCH    (PCH),
    .fix    (fix)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, pending=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // m_abh/m_pch/m_ahh are the architectural bytes; m_in_fix marks that the
  // next enabled cycle must present the corrected page m_target.
  logic [7:0] m_abh, m_pch, m_ahh, m_target;
  bit         m_in_fix;

  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; rdy = 1'b1; op = ABH_HOLD; DB = 8'h00; CI = 1'b0; neg = 1'b0;
    ld_ahh = 1'b0; ld_pc = 1'b0; pcl_co = 1'b0;
    m_abh = 8'h00; m_pch = 8'h00; m_ahh = 8'h00; m_in_fix = 1'b0; m_target = 8'h00;
    exp_q.push_back({1'b0, 8'h00, 8'h00, 8'h00});
  endtask

  task automatic drive(input logic [3:0] t_op, input logic [7:0] t_db,
                       input logic t_ci, input logic t_neg,
                       input logic t_ld_ahh, input logic t_ld_pc,
                       input logic t_pcl_co, input logic t_rdy);
    logic [7:0] e_adh, base, target;
    logic       e_fix, is_addr;
    @(posedge clk); #1;
    rst = 1'b0; op = t_op; DB = t_db; CI = t_ci; neg = t_neg;
    ld_ahh = t_ld_ahh; ld_pc = t_ld_pc; pcl_co = t_pcl_co; rdy = t_rdy;

    e_fix = 1'b0; is_addr = 1'b0; base = 8'h00; target = 8'h00; e_adh = m_abh;
    if (m_in_fix) begin
      e_adh = m_target;
    end else begin
      case (t_op)
        4'h0: e_adh = m_abh;
        4'h1: e_adh = m_pch;
        4'h2: e_adh = m_abh + {7'd0, t_ci};
        4'h3: e_adh = 8'h00;
        4'h4: e_adh = 8'h01;
        4'h5: e_adh = 8'hFF;
        4'h6: begin is_addr = 1'b1; base = t_db;  target = t_db + {7'd0, t_ci}; end
        4'h7: begin is_addr = 1'b1; base = m_ahh; target = m_ahh + {7'd0, t_ci}; end
        4'h8: begin
          is_addr = 1'b1; base = m_abh;
          target = t_neg ? (m_abh - 8'd1 + {7'd0, t_ci}) : (m_abh + {7'd0, t_ci});
        end
        default: e_adh = m_abh;
      endcase
      // A page cross means the final page differs from the starting page.
      if (is_addr) begin
        if (FIX_EN && (target != base)) begin
          e_adh = base;
          e_fix = 1'b1;
        end else begin
          e_adh = target;
        end
      end
    end

    exp_q.push_back({e_fix, e_adh, m_abh, m_pch});

    if (t_rdy) begin
      if (t_ld_pc)  m_pch = m_abh + {7'd0, t_pcl_co};
      if (t_ld_ahh) m_ahh = t_db;
      m_abh    = e_adh;
      m_in_fix = e_fix;
      m_target = target;
    end
  endtask

  task automatic simple(input logic [3:0] t_op, input logic [7:0] t_db,
                        input logic t_ci, input logic t_neg);
    drive(t_op, t_db, t_ci, t_neg, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // ---------------- scoreboard / monitor ----------------
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s at %0t: got %02h expected %02h", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("fix", {7'd0, fix}, {7'd0, e[24]});
      check("ADH", ADH, e[23:16]);
      check("ABH", ABH, e[15:8]);
      check("PCH", PCH, e[7:0]);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; rdy = 1'b1; op = ABH_HOLD; DB = 8'h00; CI = 1'b0; neg = 1'b0;
    ld_ahh = 1'b0; ld_pc = 1'b0; pcl_co = 1'b0;

    do_reset();

    // Stack and vector pages.
    simple(ABH_STK, 8'h5A, 1'b1, 1'b0);
    simple(ABH_VEC, 8'h5A, 1'b0, 1'b0);
    simple(ABH_HOLD, 8'h00, 1'b0, 1'b0);
    simple(ABH_ZP, 8'h77, 1'b1, 1'b1);

    // PC increment 12 -> 13, then FF -> 00 wrap.
    simple(ABH_ABS, 8'h12, 1'b0, 1'b0);
    drive(ABH_HOLD, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    simple(ABH_PC, 8'h00, 1'b0, 1'b0);
    simple(ABH_VEC, 8'h00, 1'b0, 1'b0);
    drive(ABH_HOLD, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    simple(ABH_PC, 8'h00, 1'b0, 1'b0);

    // ABS page cross DB=20, CI=1, then ABS boundary FF+1.
    simple(ABH_ABS, 8'h20, 1'b1, 1'b0);
    simple(ABH_HOLD, 8'h00, 1'b0, 1'b0);
    simple(ABH_ABS, 8'hFF, 1'b1, 1'b0);
    simple(ABH_BRA, 8'h00, 1'b1, 1'b1);

    // Backward branch from page 30 with and without a cross.
    simple(ABH_ABS, 8'h30, 1'b0, 1'b0);
    simple(ABH_BRA, 8'h00, 1'b0, 1'b1);
    simple(ABH_HOLD, 8'h00, 1'b0, 1'b0);
    simple(ABH_ABS, 8'h30, 1'b0, 1'b0);
    simple(ABH_BRA, 8'h00, 1'b1, 1'b1);
    simple(ABH_BRA, 8'h00, 1'b1, 1'b0);
    simple(ABH_HOLD, 8'h00, 1'b0, 1'b0);

    // IND through AHH with a cross.
    drive(ABH_HOLD, 8'h9C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    simple(ABH_IND, 8'h00, 1'b1, 1'b0);
    simple(ABH_INC, 8'h00, 1'b1, 1'b0);

    // rdy stall during FIX for 3 cycles, then release.
    simple(ABH_ABS, 8'h40, 1'b1, 1'b0);
    drive(ABH_ZP, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(ABH_VEC, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(ABH_ABS, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    simple(ABH_STK, 8'h00, 1'b0, 1'b0);
    simple(ABH_HOLD, 8'h00, 1'b0, 1'b0);

    // Reset asserted while in FIX, then ABS without carry.
    simple(ABH_ABS, 8'h66, 1'b1, 1'b0);
    do_reset();
    simple(ABH_ABS, 8'h55, 1'b0, 1'b0);
    simple(ABH_HOLD, 8'h00, 1'b0, 1'b0);

    // Randomized traffic, biased toward page-crossing ops.
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] r_op;
      int sel;
      sel = $urandom_range(0, 23);
      if (sel < 16) r_op = 4'(sel);
      else r_op = 4'(6 + (sel % 3));
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        drive(r_op, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 4) != 0));
      end
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
